inst_cache_dm: RTL and testbench

INST_CACHE_DM -- requirements
Module: inst_cache_dm

---
 rtl/inst_cache_dm.sv | 184 ++++++++++++++++++
 tb/tb_inst_cache_dm.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_cache_dm.sv
// Direct-mapped instruction cache with word-by-word line refill and an uncached
// address window that goes straight to memory without allocating a line.
module inst_cache_dm #(
  parameter int          NUM_LINES      = 16,
  parameter int          WORDS_PER_LINE = 4,
  parameter logic [15:0] UNCACHED_HI    = 16'h1c09
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_valid,
  input  logic [31:0] cpu_addr,
  input  logic        flush,
  output logic [31:0] cpu_inst,
  output logic        cpu_inst_valid,
  output logic        cpu_stall,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  input  logic        mem_req_ready,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data
);

  localparam int OB = $clog2(WORDS_PER_LINE);
  localparam int IB = $clog2(NUM_LINES);
  localparam int TW = 30 - OB - IB;
  localparam int CW = (OB < 1) ? 1 : OB;
  localparam logic [CW-1:0] LAST = CW'(WORDS_PER_LINE - 1);

  typedef enum logic [2:0] {IDLE, MISS_REQ, MISS_WAIT, UC_REQ, UC_WAIT, DONE} state_t;

  state_t               r_state;
  logic [NUM_LINES-1:0] r_valid;
  logic [TW-1:0]        r_tags [NUM_LINES];
  logic [31:0]          r_data [NUM_LINES][WORDS_PER_LINE];
  logic [CW-1:0]        r_wordCnt;
  logic [CW-1:0]        r_offset;
  logic [IB-1:0]        r_index;
  logic [TW-1:0]        r_tag;
  logic [29:0]          r_lineBase;
  logic                 r_flushPending;
  logic [31:0]          r_ret;
  logic                 r_memReqValid;
  logic [31:0]          r_memReqAddr;

  logic [29:0]   w_wordAddr;
  logic [CW-1:0] w_offset;
  logic [IB-1:0] w_index;
  logic [TW-1:0] w_tag;
  logic [29:0]   w_lineBase;
  logic [CW-1:0] w_nextCnt;
  logic          w_uncached;
  logic          w_hit;
  logic          w_lastWord;
  logic          w_flushNow;
  logic          w_unused;

  assign w_wordAddr = cpu_addr[31:2];
  assign w_offset   = CW'(w_wordAddr & 30'(WORDS_PER_LINE - 1));
  assign w_index    = IB'(w_wordAddr >> OB);
  assign w_tag      = TW'(w_wordAddr >> (OB + IB));
  assign w_lineBase = w_wordAddr & ~30'(WORDS_PER_LINE - 1);
  assign w_nextCnt  = r_wordCnt + CW'(1);
  assign w_uncached = (cpu_addr[31:16] == UNCACHED_HI);
  assign w_lastWord = (r_wordCnt == LAST);
  assign w_flushNow = r_flushPending | flush;
  assign w_unused   = ^cpu_addr[1:0];
  // A flush in the same cycle as a lookup forces a miss.
  assign w_hit      = !w_uncached && !flush && r_valid[w_index] && (r_tags[w_index] == w_tag);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state        <= IDLE;
      r_valid        <= '0;
      r_wordCnt      <= '0;
      r_offset       <= '0;
      r_index        <= '0;
      r_tag          <= '0;
      r_lineBase     <= '0;
      r_flushPending <= 1'b0;
      r_ret          <= '0;
      r_memReqValid  <= 1'b0;
      r_memReqAddr   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (flush) r_valid <= '0;
          if (cpu_valid && w_uncached) begin
            r_state       <= UC_REQ;
            r_memReqValid <= 1'b1;
            r_memReqAddr  <= {w_wordAddr, 2'b00};
          end else if (cpu_valid && !w_hit) begin
            r_state       <= MISS_REQ;
            r_wordCnt     <= '0;
            r_offset      <= w_offset;
            r_index       <= w_index;
            r_tag         <= w_tag;
            r_lineBase    <= w_lineBase;
            r_memReqValid <= 1'b1;
            r_memReqAddr  <= {w_lineBase, 2'b00};
          end
        end
        MISS_REQ: begin
          r_flushPending <= w_flushNow;
          if (mem_req_ready) begin
            r_state       <= MISS_WAIT;
            r_memReqValid <= 1'b0;
            r_memReqAddr  <= '0;
          end
        end
        MISS_WAIT: begin
          r_flushPending <= w_flushNow;
          if (mem_resp_valid) begin
            if (r_wordCnt == r_offset) r_ret <= mem_resp_data;
            if (w_lastWord) begin
              r_state <= DONE;
              // A flush seen at any point of the fill wins over allocating the line.
              if (w_flushNow) r_valid <= '0;
              else            r_valid[r_index] <= 1'b1;
            end else begin
              r_wordCnt     <= w_nextCnt;
              r_state       <= MISS_REQ;
              r_memReqValid <= 1'b1;
              r_memReqAddr  <= {r_lineBase + 30'(w_nextCnt), 2'b00};
            end
          end
        end
        UC_REQ: begin
          r_flushPending <= w_flushNow;
          if (mem_req_ready) begin
            r_state       <= UC_WAIT;
            r_memReqValid <= 1'b0;
            r_memReqAddr  <= '0;
          end
        end
        UC_WAIT: begin
          r_flushPending <= w_flushNow;
          if (mem_resp_valid) begin
            r_ret   <= mem_resp_data;
            r_state <= DONE;
            if (w_flushNow) r_valid <= '0;
          end
        end
        DONE: begin
          if (flush) r_valid <= '0;
          r_flushPending <= 1'b0;
          r_state        <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset && r_state == MISS_WAIT && mem_resp_valid) begin
      r_data[r_index][r_wordCnt] <= mem_resp_data;
      if (w_lastWord) r_tags[r_index] <= r_tag;
    end
  end

  always_comb begin
    cpu_inst       = '0;
    cpu_inst_valid = 1'b0;
    cpu_stall      = 1'b0;
    if (reset) begin
      if (r_state == IDLE) begin
        if (cpu_valid && w_hit) begin
          cpu_inst       = r_data[w_index][w_offset];
          cpu_inst_valid = 1'b1;
        end else if (cpu_valid) begin
          cpu_stall = 1'b1;
        end
      end else if (r_state == DONE) begin
        cpu_inst       = r_ret;
        cpu_inst_valid = 1'b1;
      end else begin
        cpu_stall = 1'b1;
      end
    end
  end

  assign mem_req_valid = reset & r_memReqValid;
  assign mem_req_addr  = reset ? r_memReqAddr : 32'h0;

endmodule

// File: tb/tb_inst_cache_dm.sv
// Scoreboard bench for inst_cache_dm: a line-level cache model predicts every
// fetched word, its hit/miss timing and the exact memory request sequence.
module tb_inst_cache_dm;

  localparam int NL  = 16;
  localparam int WPL = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_valid = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic        flush = 1'b0;
  logic [31:0] cpu_inst;
  logic        cpu_inst_valid;
  logic        cpu_stall;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready = 1'b0;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_resp_data = '0;

  inst_cache_dm dut (
    .clk            (clk),
    .reset          (reset),
    .cpu_valid      (cpu_valid),
    .cpu_addr       (cpu_addr),
    .flush          (flush),
    .cpu_inst       (cpu_inst),
    .cpu_inst_valid (cpu_inst_valid),
    .cpu_stall      (cpu_stall),
    .mem_req_valid  (mem_req_valid),
    .mem_req_addr   (mem_req_addr),
    .mem_req_ready  (mem_req_ready),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    bit          hit;
  } exp_t;

  int          compared = 0;
  int          mismatched = 0;
  exp_t        expQ[$];
  logic [31:0] expReqQ[$];
  logic [31:0] memOverride [logic [31:0]];
  bit          modelValid [NL];
  logic [31:0] modelTag [NL];
  int          hsCount = 0;
  int          memLat = 0;
  int          readyLowLeft = 0;
  bit          randomReady = 0;
  bit          spurious = 0;

  function automatic logic [31:0] memData(input logic [31:0] a);
    if (memOverride.exists(a)) return memOverride[a];
    return (a * 32'h9E3779B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  function automatic void modelClear();
    for (int i = 0; i < NL; i++) modelValid[i] = 1'b0;
  endfunction

  // Cache behaviour from first principles: line = WPL words, index/tag by division.
  function automatic void modelIssue(input logic [31:0] addr, input bit flushWithReq, input bit flushInFill);
    logic [31:0] wa   = addr & ~32'h3;
    bit          unc  = (addr[31:16] == 16'h1c09);
    int          idx  = int'((addr / (4 * WPL)) % NL);
    logic [31:0] tag  = addr / (4 * WPL * NL);
    logic [31:0] base = addr - (addr % (4 * WPL));
    exp_t        e;
    if (flushWithReq) modelClear();
    e.hit  = !unc && modelValid[idx] && (modelTag[idx] == tag);
    e.inst = memData(wa);
    expQ.push_back(e);
    if (unc) begin
      expReqQ.push_back(wa);
    end else if (!e.hit) begin
      for (int i = 0; i < WPL; i++) expReqQ.push_back(base + 32'(4 * i));
      if (flushInFill) modelClear();
      else begin
        modelValid[idx] = 1'b1;
        modelTag[idx]   = tag;
      end
    end
  endfunction

  // One fetch; flushAtWord >= 0 pulses flush once that many fill requests were accepted.
  task automatic applyStimulus(input logic [31:0] addr, input bit flushWithReq, input int flushAtWord);
    int startHs;
    bit got = 0;
    bit flushDone = 0;
    modelIssue(addr, flushWithReq, flushAtWord >= 0);
    startHs = hsCount;
    @(posedge clk); #1;
    cpu_valid = 1'b1;
    cpu_addr  = addr;
    flush     = flushWithReq;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (cpu_inst_valid) begin
        got = 1;
        break;
      end
      @(posedge clk); #1;
      flush = 1'b0;
      if (flushAtWord >= 0 && !flushDone && (hsCount - startHs) >= flushAtWord) begin
        flush     = 1'b1;
        flushDone = 1;
      end
    end
    if (!got) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL fetch_timeout: addr 0x%08h saw no cpu_inst_valid, required within 400 cycles", addr);
    end
    @(posedge clk); #1;
    cpu_valid = 1'b0;
    flush     = 1'b0;
  endtask

  // Starts a miss, pulls reset while the first word is outstanding, then refetches.
  task automatic resetMidFill(input logic [31:0] addr);
    int startHs;
    bit seen = 0;
    logic [31:0] base = addr - (addr % (4 * WPL));
    memLat = 2;
    for (int i = 0; i < WPL; i++) expReqQ.push_back(base + 32'(4 * i));
    startHs = hsCount;
    @(posedge clk); #1;
    cpu_valid = 1'b1;
    cpu_addr  = addr;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #2;
      if (hsCount > startHs) begin
        seen = 1;
        break;
      end
    end
    if (!seen) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL reset_fill_start: no fill request accepted, required within 100 cycles");
    end
    reset     = 1'b0;
    cpu_valid = 1'b0;
    expReqQ.delete();
    @(negedge clk);
    checkOutput("rst_fill_inst", cpu_inst, 32'h0);
    checkOutput("rst_fill_inst_valid", 32'(cpu_inst_valid), 32'h0);
    checkOutput("rst_fill_stall", 32'(cpu_stall), 32'h0);
    checkOutput("rst_fill_req_valid", 32'(mem_req_valid), 32'h0);
    checkOutput("rst_fill_req_addr", mem_req_addr, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    modelClear();
    repeat (5) @(posedge clk);
    memLat = 0;
    applyStimulus(addr, 0, -1);
  endtask

  // Memory: records and checks every accepted request, returns one word after memLat cycles.
  initial begin
    bit          hs;
    logic [31:0] a;
    logic [31:0] respAddr = '0;
    int          respCnt = -1;
    forever begin
      @(negedge clk);
      hs = mem_req_valid && mem_req_ready;
      a  = mem_req_addr;
      @(posedge clk); #1;
      mem_resp_valid = 1'b0;
      if (hs) begin
        hsCount++;
        if (expReqQ.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL req_unexpected: got request at 0x%08h, required none", a);
        end else begin
          checkOutput("req_addr", a, expReqQ.pop_front());
        end
        respAddr = a;
        respCnt  = memLat;
      end
      if (respCnt == 0) begin
        mem_resp_valid = 1'b1;
        mem_resp_data  = memData(respAddr);
        respCnt        = -1;
      end else if (respCnt > 0) begin
        respCnt--;
      end else if (spurious && $urandom_range(0, 7) == 0) begin
        mem_resp_valid = 1'b1;
        mem_resp_data  = $urandom;
      end
      if (readyLowLeft > 0) begin
        mem_req_ready = 1'b0;
        if (mem_req_valid) readyLowLeft--;
      end else begin
        mem_req_ready = randomReady ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
    end
  end

  // Monitor: pops the scoreboard on every delivered instruction.
  bit          stallSeen = 0;
  bit          prevReqWait = 0;
  logic [31:0] prevReqAddr = '0;
  exp_t        monExp;

  always @(negedge clk) begin
    if (!reset) begin
      stallSeen   = 0;
      prevReqWait = 0;
    end else begin
      if (cpu_inst_valid) begin
        if (expQ.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL inst_unexpected: got 0x%08h, required no delivery", cpu_inst);
        end else begin
          monExp = expQ.pop_front();
          checkOutput("inst", cpu_inst, monExp.inst);
          checkOutput("hit", 32'(!stallSeen), 32'(monExp.hit));
          checkOutput("stall_with_valid", 32'(cpu_stall), 32'h0);
        end
        stallSeen = 0;
      end else begin
        checkOutput("inst_zero", cpu_inst, 32'h0);
        if (cpu_stall) stallSeen = 1;
      end
      if (prevReqWait) begin
        checkOutput("req_hold_valid", 32'(mem_req_valid), 32'h1);
        checkOutput("req_hold_addr", mem_req_addr, prevReqAddr);
      end
      prevReqWait = mem_req_valid && !mem_req_ready;
      prevReqAddr = mem_req_addr;
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] addr;
    bit          unc;
    int          faw;
    modelClear();
    for (int i = 0; i < WPL; i++) memOverride[32'h40 + 32'(4 * i)] = 32'hA0 + 32'(i);
    memOverride[32'h1c09_0010] = 32'hDEAD_BEEF;

    @(negedge clk);
    checkOutput("rst_inst", cpu_inst, 32'h0);
    checkOutput("rst_inst_valid", 32'(cpu_inst_valid), 32'h0);
    checkOutput("rst_stall", 32'(cpu_stall), 32'h0);
    checkOutput("rst_req_valid", 32'(mem_req_valid), 32'h0);
    checkOutput("rst_req_addr", mem_req_addr, 32'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);

    $display("[TB] cold miss and hit");
    applyStimulus(32'h0000_0048, 0, -1);
    applyStimulus(32'h0000_0044, 0, -1);

    $display("[TB] conflict refill");
    applyStimulus(32'h0000_0440, 0, -1);
    applyStimulus(32'h0000_0040, 0, -1);

    $display("[TB] uncached");
    applyStimulus(32'h1c09_0010, 0, -1);
    applyStimulus(32'h1c09_0010, 0, -1);

    $display("[TB] ready held low");
    readyLowLeft = 3;
    applyStimulus(32'h0000_0084, 0, -1);
    applyStimulus(32'h0000_0088, 0, -1);

    $display("[TB] flush during fill");
    applyStimulus(32'h0000_00C8, 0, 2);
    applyStimulus(32'h0000_00C8, 0, -1);
    applyStimulus(32'h0000_004C, 0, -1);

    $display("[TB] flush with request");
    applyStimulus(32'h0000_0040, 1, -1);
    applyStimulus(32'h0000_0044, 0, -1);

    $display("[TB] reset mid fill");
    resetMidFill(32'h0000_0104);

    $display("[TB] random traffic");
    randomReady = 1;
    spurious    = 1;
    for (int n = 0; n < 300; n++) begin
      memLat = $urandom_range(0, 2);
      unc    = ($urandom_range(0, 7) == 0);
      if (unc) addr = 32'h1c09_0000 | (32'($urandom_range(0, 63)) << 2);
      else addr = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 15)) << 4)
                  | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
      faw = (!unc && $urandom_range(0, 15) == 0) ? $urandom_range(1, 2) : -1;
      applyStimulus(addr, $urandom_range(0, 15) == 0, faw);
    end
    spurious = 0;

    repeat (10) @(posedge clk);
    checkOutput("scoreboard_drained", 32'(expQ.size()), 32'h0);
    checkOutput("requests_drained", 32'(expReqQ.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
